// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the bit-serial adder/subtractor.
//
// Contents:
//   sa_state_t - sequencing states (IDLE, RUN, DONE)
//   cnt_w()    - bit-counter width for a given operand width
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } sa_state_t;

    // One extra code point is kept so the counter cannot wrap at WIDTH=64.
    function automatic int unsigned cnt_w(input int unsigned width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/serial_adder_full_adder.sv
// One-bit combinational full adder, used as the bit slice of serial_adder.
//
// Ports:
//   a, b  - addend bits
//   cin   - carry in
//   sum   - a ^ b ^ cin
//   cout  - majority(a, b, cin)
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one full-adder slice plus a carry flop computes a
// WIDTH-bit result LSB first, one bit per clock, with a start/busy/done handshake.
//
// Parameters:
//   WIDTH - operand/result width, 1..64
//
// Ports:
//   clk   - rising-edge clock
//   rst   - synchronous active-high reset
//   start - request, sampled only in IDLE
//   a, b  - operands, captured on an accepted start
//   cin   - carry in (add mode only), captured on an accepted start
//   sub   - 0: a+b+cin, 1: a-b
//   busy  - operation in progress
//   done  - one-cycle pulse, result valid
//   sum   - result, held until the next accepted start
//   cout  - carry out of the MSB (sub mode: 1 = no borrow)
//   ovf   - two's-complement overflow; present only when SERIAL_ADDER_OVF_EN is defined
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned CW = cnt_w(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    sa_state_t        state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, b_sh_q, sum_q, sum_shifted;
    logic             carry_q, cout_q;
    logic [CW-1:0]    cnt_q;
    logic             slice_s, slice_c;
    logic             accept, last_bit;

    full_adder u_slice (
        .a    (a_sh_q[0]),
        .b    (b_sh_q[0]),
        .cin  (carry_q),
        .sum  (slice_s),
        .cout (slice_c)
    );

    assign accept   = (state_q == IDLE) && start;
    assign last_bit = (state_q == RUN) && (cnt_q == LAST);

    // Result bits enter from the MSB so after WIDTH shifts bit 0 lands in sum[0].
    if (WIDTH == 1) begin : g_sum_w1
        assign sum_shifted = slice_s;
    end else begin : g_sum_wn
        assign sum_shifted = {slice_s, sum_q[WIDTH-1:1]};
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (cnt_q == LAST) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs decoded from state.
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        unique case (state_q)
            RUN:     busy = 1'b1;
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    // Datapath: operand shifters, carry, bit counter and result.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else if (accept) begin
            a_sh_q  <= a;
            // Subtraction is a + ~b + 1; cin is deliberately ignored in that mode.
            b_sh_q  <= sub ? ~b : b;
            carry_q <= sub ? 1'b1 : cin;
            cnt_q   <= '0;
            sum_q   <= '0;
        end else if (state_q == RUN) begin
            a_sh_q  <= a_sh_q >> 1;
            b_sh_q  <= b_sh_q >> 1;
            carry_q <= slice_c;
            cnt_q   <= cnt_q + CW'(1);
            sum_q   <= sum_shifted;
            if (last_bit) begin
                cout_q <= slice_c;
            end
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;

`ifdef SERIAL_ADDER_OVF_EN
    logic ovf_q;

    // Overflow is carry into the MSB xor carry out of it, i.e. carry_q ^ slice_c
    // while the last bit is in the slice.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (accept) begin
            ovf_q <= 1'b0;
        end else if (last_bit) begin
            ovf_q <= carry_q ^ slice_c;
        end
    end

    assign ovf = ovf_q;
`endif

endmodule
